// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair; one result bit per cycle, Done pulse on write.
// Define HILO_MACC_EN to implement MADD/MSUB (Op 4/5); otherwise those requests are ignored.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  logic [1:0]         state;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               res_neg;
  logic               rem_neg;
  logic               div_zero;
`ifdef HILO_MACC_EN
  logic               accum;
  logic               sub;
`endif

  logic               arith_op;
  logic               signed_op;
  logic               div_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [2*WIDTH-1:0] mul_result;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] result;

`ifdef HILO_MACC_EN
  assign arith_op = (Op != OP_MTHI) && (Op != OP_MTLO);
`else
  assign arith_op = (Op[2] == 1'b0);
`endif
  assign signed_op = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
  assign div_op    = (Op[2:1] == 2'b01);
  assign a_neg     = signed_op & A[WIDTH-1];
  assign b_neg     = signed_op & B[WIDTH-1];
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;

  assign Busy = (state == S_RUN) || (state == S_FIX);

  // acc holds {partial product, multiplier} for multiply, {remainder, dividend/quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (is_div) begin
      if (div_diff[WIDTH])
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Divide by zero leaves |A| as remainder; the dividend-sign fix then restores A exactly
  always_comb begin
    quo      = acc[WIDTH-1:0];
    rem      = acc[2*WIDTH-1:WIDTH];
    prod_fix = res_neg ? -acc : acc;
    quo_fix  = div_zero ? '1 : (res_neg ? -quo : quo);
    rem_fix  = rem_neg ? -rem : rem;
`ifdef HILO_MACC_EN
    if (accum)
      mul_result = sub ? ({Hi, Lo} - prod_fix) : ({Hi, Lo} + prod_fix);
    else
      mul_result = prod_fix;
`else
    mul_result = prod_fix;
`endif
    result = is_div ? {rem_fix, quo_fix} : mul_result;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= S_IDLE;
      count     <= '0;
      acc       <= '0;
      opnd      <= '0;
      is_div    <= 1'b0;
      res_neg   <= 1'b0;
      rem_neg   <= 1'b0;
      div_zero  <= 1'b0;
`ifdef HILO_MACC_EN
      accum     <= 1'b0;
      sub       <= 1'b0;
`endif
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start && !Flush) begin
            if (Op == OP_MTHI) begin
              Hi <= A;
            end else if (Op == OP_MTLO) begin
              Lo <= A;
            end else if (arith_op) begin
              state    <= S_RUN;
              count    <= '0;
              is_div   <= div_op;
              res_neg  <= a_neg ^ b_neg;
              rem_neg  <= a_neg;
              div_zero <= div_op && (B == '0);
              acc      <= div_op ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
              opnd     <= div_op ? b_mag : a_mag;
`ifdef HILO_MACC_EN
              accum    <= Op[2];
              sub      <= Op[0];
`endif
            end
          end
        end
        S_RUN: begin
          if (Flush) begin
            state <= S_IDLE;
          end else begin
            acc   <= acc_next;
            count <= count + CNT_W'(1);
            if (count == CNT_W'(WIDTH - 1))
              state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!Flush) begin
            {Hi, Lo}  <= result;
            Done      <= 1'b1;
            DivByZero <= div_zero;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: a 32-bit instance for the main vectors and an 8-bit one.
module tb_hilo_muldiv_unit;
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic        Clk;
  logic        Rst;
  logic        Start, Flush;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, Dbz;
  logic [31:0] Hi, Lo;

  logic        start8, flush8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;
  int   n_cmp = 0;
  int   n_bad = 0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B), .Flush(Flush),
    .Busy(Busy), .Done(Done), .DivByZero(Dbz), .Hi(Hi), .Lo(Lo)
  );

  hilo_muldiv_unit #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Rst(Rst), .Start(start8), .Op(op8), .A(a8), .B(b8), .Flush(flush8),
    .Busy(busy8), .Done(done8), .DivByZero(dbz8), .Hi(hi8), .Lo(lo8)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitors: every Done pulse must match the oldest outstanding expectation
  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      if (q32.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done32: got Done=1, expected no completion");
      end else begin
        e32 = q32.pop_front();
        chk("hi32", {32'd0, Hi}, {32'd0, e32.hi});
        chk("lo32", {32'd0, Lo}, {32'd0, e32.lo});
        chk("dbz32", {63'd0, Dbz}, {63'd0, e32.dbz});
      end
    end
  end

  always @(negedge Clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done8: got Done=1, expected no completion");
      end else begin
        e8 = q8.pop_front();
        chk("hi8", {56'd0, hi8}, {56'd0, e8.hi[7:0]});
        chk("lo8", {56'd0, lo8}, {56'd0, e8.lo[7:0]});
        chk("dbz8", {63'd0, dbz8}, {63'd0, e8.dbz});
      end
    end
  end

  // Called at a negedge; returns at the following negedge (one edge after Start)
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Returns at the negedge where Done is presented
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    exp_t e;
    int   cnt;
    e.hi = ehi; e.lo = elo; e.dbz = edbz;
    q32.push_back(e);
    issue(op, a, b);
    cnt = 0;
    while (Busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge Clk);
    end
    chk("busy_cycles", 64'(cnt), 64'd33);
  endtask

  initial begin
    exp_t e;
    int   cnt;
    Rst = 1'b0; Start = 1'b0; Flush = 1'b0; Op = 3'd0; A = '0; B = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;
    #12;
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_done", {63'd0, Done}, 64'd0);
    chk("rst_dbz", {63'd0, Dbz}, 64'd0);
    chk("rst_hilo", {Hi, Lo}, 64'd0);
    chk("rst_busy8", {63'd0, busy8}, 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    // MTHI, then a flushed MULTU with an ignored Start while busy
    issue(3'd6, 32'h12, 32'd0);
    chk("mthi_hi", {32'd0, Hi}, 64'h12);
    chk("mthi_nobusy", {63'd0, Busy}, 64'd0);
    issue(3'd1, 32'd3, 32'd4);
    repeat (3) @(negedge Clk);
    issue(3'd0, 32'd9, 32'd9);
    repeat (5) @(negedge Clk);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    chk("flush_busy", {63'd0, Busy}, 64'd0);
    chk("flush_hilo", {Hi, Lo}, 64'h0000_0012_0000_0000);
    repeat (40) @(negedge Clk);
    chk("flush_quiet_busy", {63'd0, Busy}, 64'd0);
    chk("flush_quiet_hilo", {Hi, Lo}, 64'h0000_0012_0000_0000);

    // Flush with Start in IDLE drops the Start
    Flush = 1'b1;
    issue(3'd7, 32'h55, 32'd0);
    Flush = 1'b0;
    chk("flush_start_lo", {32'd0, Lo}, 64'd0);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    @(negedge Clk);
    chk("done_one_cycle", {63'd0, Done}, 64'd0);
    // back-to-back chain: each Start lands in the previous Done cycle
    run_op(3'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0, 32'h1E, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
    run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op(3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    @(negedge Clk);
    chk("dbz_clear", {63'd0, Dbz}, 64'd0);
    chk("dbz_done_clear", {63'd0, Done}, 64'd0);

    // MTHI in the Done cycle overrides the product's high half
    run_op(3'd1, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0);
    issue(3'd6, 32'hABCD, 32'd0);
    chk("mthi_override", {Hi, Lo}, 64'h0000_ABCD_0000_0000);

`ifdef HILO_MACC_EN
    issue(3'd6, 32'd0, 32'd0);
    issue(3'd7, 32'h10, 32'd0);
    run_op(3'd4, 32'd2, 32'd3, 32'd0, 32'h16, 1'b0);
    issue(3'd7, 32'h10, 32'd0);
    run_op(3'd5, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b0);
    @(negedge Clk);
`else
    issue(3'd6, 32'h21, 32'd0);
    issue(3'd7, 32'h10, 32'd0);
    issue(3'd4, 32'd2, 32'd3);
    chk("madd_off_busy", {63'd0, Busy}, 64'd0);
    issue(3'd5, 32'd5, 32'd5);
    chk("msub_off_busy", {63'd0, Busy}, 64'd0);
    repeat (40) @(negedge Clk);
    chk("macc_off_hilo", {Hi, Lo}, 64'h0000_0021_0000_0010);
`endif

    // 8-bit instance: MULT -3 * 7
    e.hi = 32'hFF; e.lo = 32'hEB; e.dbz = 1'b0;
    q8.push_back(e);
    start8 = 1'b1; op8 = 3'd0; a8 = 8'hFD; b8 = 8'd7;
    @(negedge Clk);
    start8 = 1'b0;
    cnt = 0;
    while (busy8 === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge Clk);
    end
    chk("busy8_cycles", 64'(cnt), 64'd9);

    // Asynchronous reset in the middle of a DIV
    issue(3'd6, 32'h77, 32'd0);
    issue(3'd2, 32'd1000, 32'd3);
    repeat (18) @(negedge Clk);
    chk("pre_rst_busy", {63'd0, Busy}, 64'd1);
    Rst = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, Busy}, 64'd0);
    chk("mid_rst_hilo", {Hi, Lo}, 64'd0);
    chk("mid_rst_done", {63'd0, Done}, 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    repeat (40) @(negedge Clk);
    chk("post_rst_hilo", {Hi, Lo}, 64'd0);
    chk("sb32_drained", 64'(q32.size()), 64'd0);
    chk("sb8_drained", 64'(q8.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
